dw_div_rem_seq: RTL

//  Multi-cycle sequential integer divider: quotient, remainder, divide-by-zero flag.

---
 rtl/dw_div_rem_seq_pkg.sv | 40 ++++
 rtl/dw_div_rem_seq_if.sv | 28 ++
 rtl/dw_div_rem_seq_step.sv | 36 +++
 rtl/dw_div_rem_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dw_div_rem_seq_pkg.sv
// Shared types and constant helpers for the sequential divider.
// Saturation helpers return 64-bit patterns; callers truncate to their operand width.
package dw_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_W = 64;

  function automatic int clog2(input int x);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < x) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [MAX_W-1:0] all_ones(input int w);
    return (w >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Largest positive two's-complement value of width w: 0111..1
  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    return all_ones(w - 1);
  endfunction

  // Most negative two's-complement value of width w: 1000..0
  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/dw_div_rem_seq_if.sv
// Operand/result bundle of the sequential divider.
// master drives operands and control, slave returns results.
interface dw_div_rem_seq_if #(
  parameter int A_WIDTH = 14,
  parameter int B_WIDTH = 9
);

  logic               hold;
  logic               start;
  logic               tc;
  logic [A_WIDTH-1:0] a;
  logic [B_WIDTH-1:0] b;
  logic               complete;
  logic               divide_by_0;
  logic [A_WIDTH-1:0] quotient;
  logic [B_WIDTH-1:0] remainder;

  modport master (
    output hold, start, tc, a, b,
    input  complete, divide_by_0, quotient, remainder
  );

  modport slave (
    input  hold, start, tc, a, b,
    output complete, divide_by_0, quotient, remainder
  );

endinterface

// File: rtl/dw_div_rem_seq_step.sv
// Combinational slice of the divider core: STEPS chained non-restoring
// shift/add-or-subtract iterations on the (B_WIDTH+1)-bit partial remainder.
module dw_div_step #(
  parameter int B_WIDTH = 9,
  parameter int QW      = 14,
  parameter int STEPS   = 1
) (
  input  logic [B_WIDTH:0]   i_rem,
  input  logic [QW-1:0]      i_quo,
  input  logic [B_WIDTH-1:0] i_div,
  output logic [B_WIDTH:0]   o_rem,
  output logic [QW-1:0]      o_quo
);

  logic [B_WIDTH:0] w_rem;
  logic [B_WIDTH:0] w_sh;
  logic [QW-1:0]    w_quo;

  // NOTE: blocking assignments here chain one iteration into the next within
  // a single evaluation; each variable also gets a value before any branch so
  // no latch is inferred.
  always_comb begin
    w_rem = i_rem;
    w_quo = i_quo;
    w_sh  = '0;
    for (int k = 0; k < STEPS; k++) begin
      w_sh  = {w_rem[B_WIDTH-1:0], w_quo[QW-1]};
      // The remainder stays within [-|b|, |b|), so B_WIDTH+1 bits never overflow.
      w_rem = w_rem[B_WIDTH] ? (w_sh + {1'b0, i_div}) : (w_sh - {1'b0, i_div});
      w_quo = {w_quo[QW-2:0], ~w_rem[B_WIDTH]};
    end
    o_rem = w_rem;
    o_quo = w_quo;
  end

endmodule

// File: rtl/dw_div_rem_seq.sv
// Multi-cycle integer divider: magnitudes are divided by a non-restoring core,
// then signs, remainder correction and special cases are applied in one FIX cycle.
module dw_div_rem_seq
  import dw_div_pkg::*;
#(
  parameter int A_WIDTH      = 14,
  parameter int B_WIDTH      = 9,
  parameter int TC_MODE      = 1,
  parameter int BITS_PER_CYC = 1
) (
  input logic            clk,
  input logic            rst_n,
  dw_div_rem_seq_if.slave bus
);

  localparam int N     = (A_WIDTH + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int QW    = N * BITS_PER_CYC;
  localparam int CNT_W = clog2(N + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(N - 1);
  localparam logic [A_WIDTH-1:0] Q_SAT_POS = A_WIDTH'(sat_pos(A_WIDTH));
  localparam logic [A_WIDTH-1:0] Q_SAT_NEG = A_WIDTH'(sat_neg(A_WIDTH));
  localparam logic [A_WIDTH-1:0] Q_ONES    = A_WIDTH'(all_ones(A_WIDTH));
  localparam logic [B_WIDTH-1:0] B_ONES    = B_WIDTH'(all_ones(B_WIDTH));

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [B_WIDTH:0]   r_rem;
  logic [QW-1:0]      r_quo;
  logic [B_WIDTH-1:0] r_div;
  logic               r_signed;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_b_zero;
  logic               r_ovf;

  logic [A_WIDTH-1:0] r_quotient;
  logic [B_WIDTH-1:0] r_remainder;
  logic               r_dbz;

  logic               w_tc_en;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [A_WIDTH-1:0] w_a_mag;
  logic [B_WIDTH-1:0] w_b_mag;
  logic [B_WIDTH:0]   w_rem_nxt;
  logic [QW-1:0]      w_quo_nxt;

  logic [B_WIDTH-1:0] w_rem_mag;
  logic [A_WIDTH-1:0] w_quo_mag;
  logic [A_WIDTH-1:0] w_q_fix;
  logic [B_WIDTH-1:0] w_r_fix;
  logic               w_dbz_fix;

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // exactly its magnitude when read back as unsigned.
  assign w_tc_en = (TC_MODE != 0) ? bus.tc : 1'b0;
  assign w_a_neg = w_tc_en & bus.a[A_WIDTH-1];
  assign w_b_neg = w_tc_en & bus.b[B_WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag = w_b_neg ? -bus.b : bus.b;

  dw_div_step #(
    .B_WIDTH (B_WIDTH),
    .QW      (QW),
    .STEPS   (BITS_PER_CYC)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.hold) begin
      if (bus.start) begin
        w_state_nxt = CALC;
      end else begin
        case (r_state)
          CALC:    if (r_cnt == CNT_LAST) w_state_nxt = FIX;
          FIX:     w_state_nxt = DONE;
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // Final correction: restore a negative partial remainder, then apply signs.
  always_comb begin
    w_rem_mag = r_rem[B_WIDTH] ? (r_rem[B_WIDTH-1:0] + r_div) : r_rem[B_WIDTH-1:0];
    w_quo_mag = r_quo[A_WIDTH-1:0];
    w_q_fix   = (r_a_neg ^ r_b_neg) ? -w_quo_mag : w_quo_mag;
    w_r_fix   = r_a_neg ? -w_rem_mag : w_rem_mag;
    w_dbz_fix = 1'b0;
    if (r_b_zero) begin
      w_dbz_fix = 1'b1;
      w_r_fix   = '0;
      w_q_fix   = r_signed ? (r_a_neg ? Q_SAT_NEG : Q_SAT_POS) : Q_ONES;
    end else if (r_ovf) begin
      w_q_fix = Q_SAT_POS;
      w_r_fix = '0;
    end
  end

  // NOTE: every register, datapath included, is cleared by the async reset so
  // the outputs read 0 immediately and nothing ever holds X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_signed    <= 1'b0;
      r_a_neg     <= 1'b0;
      r_b_neg     <= 1'b0;
      r_b_zero    <= 1'b0;
      r_ovf       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (!bus.hold) begin
      if (bus.start) begin
        r_cnt    <= '0;
        r_rem    <= '0;
        r_quo    <= QW'(w_a_mag);
        r_div    <= w_b_mag;
        r_signed <= w_tc_en;
        r_a_neg  <= w_a_neg;
        r_b_neg  <= w_b_neg;
        r_b_zero <= (bus.b == '0);
        r_ovf    <= w_tc_en & (bus.a == Q_SAT_NEG) & (bus.b == B_ONES);
      end else begin
        case (r_state)
          CALC: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          FIX: begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_dbz       <= w_dbz_fix;
          end
          default: begin
            r_cnt <= r_cnt;
          end
        endcase
      end
    end
  end

  assign bus.complete    = (r_state == IDLE) || (r_state == DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.divide_by_0 = r_dbz;

endmodule
